us_timer: RTL and testbench

Microsecond timebase and programmable countdown timer that consumes the `clk_1mhz` square wave from the clock divider. It converts that wave into a one-cycle `tick_us` strobe and keeps a free-running microsecond uptime counter. It also runs a start/stop/pause countdown in one-shot or periodic mode. Peripheral drivers in the SoC use it for µs-resolution delays and timeouts, for example sensor protocol timing.

---
 rtl/us_timer_if.sv | 28 ++
 rtl/us_timer.sv | 114 +++++++++++
 tb/tb_us_timer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/us_timer_if.sv
// Command and status bundle of the microsecond timer. The controller (master)
// drives the 1 MHz wave and the commands; the timer (slave) reports status.
interface us_timer_if #(
  parameter int CNT_W = 20,
  parameter int UP_W  = 32
) ();
  logic             clk_1mhz;
  logic             start;
  logic             stop;
  logic             pause;
  logic             periodic;
  logic [CNT_W-1:0] load_val;
  logic             tick_us;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remain;
  logic [UP_W-1:0]  uptime_us;

  modport master (
    output clk_1mhz, start, stop, pause, periodic, load_val,
    input  tick_us, busy, done, remain, uptime_us
  );

  modport slave (
    input  clk_1mhz, start, stop, pause, periodic, load_val,
    output tick_us, busy, done, remain, uptime_us
  );
endinterface

// File: rtl/us_timer.sv
// Microsecond timebase: turns the 1 MHz wave into a one-cycle tick, keeps a
// free-running uptime count and runs a one-shot / periodic countdown with
// pause and stop.
module us_timer #(
  parameter int CNT_W = 20,
  parameter int UP_W  = 32
) (
  input  logic     clk,
  input  logic     rst,
  us_timer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t           state;
  logic             prev;
  logic             tick;
  logic [UP_W-1:0]  uptime;
  logic [CNT_W-1:0] remain;
  logic [CNT_W-1:0] reload;
  logic             mode;
  logic             busy;
  logic             done;

  // Rising-edge detect of the 1 MHz wave; it already lives in this clock
  // domain, so it is sampled directly without a synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1'b0;
      tick <= 1'b0;
    end else begin
      prev <= bus.clk_1mhz;
      tick <= bus.clk_1mhz & ~prev;
    end
  end

  // Free-running uptime, wraps naturally at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uptime <= '0;
    end else if (tick) begin
      uptime <= uptime + UP_W'(1);
    end
  end

  // Countdown FSM: stop beats start, start beats pause/tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      remain <= '0;
      reload <= '0;
      mode   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.stop) begin
        state  <= IDLE;
        busy   <= 1'b0;
        remain <= '0;
      end else if (bus.start) begin
        reload <= bus.load_val;
        mode   <= bus.periodic;
        if (bus.load_val != '0) begin
          state  <= RUN;
          busy   <= 1'b1;
          remain <= bus.load_val;
        end else begin
          // Zero-length request completes at once and never auto-reloads.
          state  <= IDLE;
          busy   <= 1'b0;
          remain <= '0;
          done   <= 1'b1;
        end
      end else begin
        case (state)
          RUN: begin
            if (bus.pause) begin
              state <= PAUSE;
            end else if (tick) begin
              if (remain > CNT_W'(1)) begin
                remain <= remain - CNT_W'(1);
              end else begin
                done <= 1'b1;
                if (mode) begin
                  remain <= reload;
                end else begin
                  remain <= '0;
                  state  <= IDLE;
                  busy   <= 1'b0;
                end
              end
            end
          end
          PAUSE: begin
            if (!bus.pause) begin
              state <= RUN;
            end
          end
          default: begin
            remain <= '0;
          end
        endcase
      end
    end
  end

  assign bus.tick_us   = tick;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.remain    = remain;
  assign bus.uptime_us = uptime;

endmodule

// File: tb/tb_us_timer.sv
// Bench for us_timer: directed scenarios plus a randomized command stream,
// all compared against a cycle-level behavioural model of the timer rules.
module tb_us_timer;

  localparam int CNT_W = 20;
  localparam int UP_W  = 32;

  logic clk;
  logic rst;

  us_timer_if #(.CNT_W(CNT_W), .UP_W(UP_W)) bus ();
  us_timer_if #(.CNT_W(CNT_W), .UP_W(4))    bus4 ();

  us_timer #(.CNT_W(CNT_W), .UP_W(UP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Narrow-uptime copy sharing the same 1 MHz wave, used for the wrap check.
  us_timer #(.CNT_W(CNT_W), .UP_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  assign bus4.clk_1mhz = bus.clk_1mhz;
  assign bus4.start    = 1'b0;
  assign bus4.stop     = 1'b0;
  assign bus4.pause    = 1'b0;
  assign bus4.periodic = 1'b0;
  assign bus4.load_val = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  int period = 96;
  int ph     = 0;

  // Behavioural model state.
  logic             m_tick;
  logic             m_prev;
  logic [UP_W-1:0]  m_uptime;
  logic [CNT_W-1:0] m_remain;
  logic [CNT_W-1:0] m_reload;
  logic             m_mode;
  logic             m_busy;
  logic             m_paused;
  logic             m_done;

  task automatic model_reset();
    m_tick = 0; m_prev = 0; m_uptime = '0; m_remain = '0; m_reload = '0;
    m_mode = 0; m_busy = 0; m_paused = 0; m_done = 0;
  endtask

  // One clock edge of the timer rules, given the inputs seen at that edge.
  task automatic model_edge(input logic st, input logic sp, input logic pa,
                            input logic per, input logic [CNT_W-1:0] lv,
                            input logic c1);
    logic old_tick;
    old_tick = m_tick;
    if (old_tick) m_uptime = m_uptime + 1;
    m_done = 0;
    if (sp) begin
      m_busy = 0; m_paused = 0; m_remain = 0;
    end else if (st) begin
      m_reload = lv; m_mode = per;
      if (lv == 0) begin
        m_busy = 0; m_paused = 0; m_remain = 0; m_done = 1;
      end else begin
        m_busy = 1; m_paused = 0; m_remain = lv;
      end
    end else if (m_busy && m_paused) begin
      if (!pa) m_paused = 0;
    end else if (m_busy) begin
      if (pa) begin
        m_paused = 1;
      end else if (old_tick) begin
        if (m_remain > 1) begin
          m_remain = m_remain - 1;
        end else begin
          m_done = 1;
          if (m_mode) m_remain = m_reload;
          else begin
            m_remain = 0; m_busy = 0;
          end
        end
      end
    end
    m_tick = c1 && !m_prev;
    m_prev = c1;
  endtask

  // Advance one clock: model follows the edge, then the wave phase moves on.
  task automatic run_cycle();
    @(posedge clk);
    model_edge(bus.start, bus.stop, bus.pause, bus.periodic, bus.load_val, bus.clk_1mhz);
    @(negedge clk);
    ph = (ph + 1) % period;
    bus.clk_1mhz = (ph >= period / 2);
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.stop = 0; bus.pause = 0; bus.periodic = 0; bus.load_val = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    #1;
    model_reset();
    ph = 0;
    bus.clk_1mhz = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1;
    #1;
    checks++;
    if ({bus.tick_us, bus.busy, bus.done, bus.remain, bus.uptime_us} !== '0)
      $display("FAIL reset_state got tick=%0b busy=%0b done=%0b remain=%0d up=%0d want all 0",
               bus.tick_us, bus.busy, bus.done, bus.remain, bus.uptime_us);
    else passed++;
    @(negedge clk);
    rst = 0;
    run_cycle();
    checks++;
    if ({bus.busy, bus.done, bus.remain, bus.uptime_us} !== '0)
      $display("FAIL reset_release got busy=%0b done=%0b remain=%0d up=%0d want all 0",
               bus.busy, bus.done, bus.remain, bus.uptime_us);
    else passed++;
    $display("test_reset complete");
  endtask

  task automatic test_tick_rate();
    int nticks;
    logic last_tick;
    period = 96;
    do_reset();
    nticks = 0;
    last_tick = 0;
    for (int i = 0; i < 960; i++) begin
      run_cycle();
      if (bus.tick_us) nticks++;
      checks++;
      if ((bus.tick_us !== m_tick) || (bus.uptime_us !== m_uptime) || (bus.tick_us && last_tick))
        $display("FAIL tick_cycle%0d got tick=%0b up=%0d want tick=%0b up=%0d",
                 i, bus.tick_us, bus.uptime_us, m_tick, m_uptime);
      else passed++;
      last_tick = bus.tick_us;
    end
    checks++;
    if (nticks !== 10) $display("FAIL tick_count got %0d want 10", nticks);
    else passed++;
    checks++;
    if (bus.uptime_us !== 32'd10) $display("FAIL uptime_10 got %0d want 10", bus.uptime_us);
    else passed++;
    $display("test_tick_rate: %0d ticks in 10 periods", nticks);
  endtask

  task automatic test_oneshot();
    int ndone;
    int cyc;
    period = 8;
    do_reset();
    bus.start = 1; bus.load_val = 5; bus.periodic = 0;
    run_cycle();
    idle_inputs();
    checks++;
    if (bus.busy !== 1'b1 || bus.remain !== 20'd5)
      $display("FAIL oneshot_start got busy=%0b remain=%0d want busy=1 remain=5", bus.busy, bus.remain);
    else passed++;
    ndone = 0;
    cyc = 0;
    while (m_busy && cyc < 500) begin
      run_cycle();
      cyc++;
      if (bus.done) begin
        ndone++;
        checks++;
        if (bus.busy !== 1'b0 || bus.remain !== 20'd0)
          $display("FAIL oneshot_done_edge got busy=%0b remain=%0d want 0 0", bus.busy, bus.remain);
        else passed++;
      end
      checks++;
      if ({bus.busy, bus.done, bus.remain} !== {m_busy, m_done, m_remain})
        $display("FAIL oneshot_cycle got busy=%0b done=%0b remain=%0d want %0b %0b %0d",
                 bus.busy, bus.done, bus.remain, m_busy, m_done, m_remain);
      else passed++;
    end
    checks++;
    if (ndone !== 1 || cyc >= 500) $display("FAIL oneshot_done_count got %0d (cycles %0d) want 1", ndone, cyc);
    else passed++;
    $display("test_oneshot: done after %0d cycles", cyc);
  endtask

  task automatic test_periodic();
    int nt, ndone, cyc;
    period = 8;
    do_reset();
    bus.start = 1; bus.load_val = 3; bus.periodic = 1;
    run_cycle();
    idle_inputs();
    nt = 0; ndone = 0; cyc = 0;
    while (nt < 10 && cyc < 1000) begin
      if (bus.tick_us) nt++;
      run_cycle();
      cyc++;
      if (bus.done) begin
        ndone++;
        checks++;
        if (bus.remain !== 20'd3 || bus.busy !== 1'b1 || (nt % 3) != 0)
          $display("FAIL periodic_reload got remain=%0d busy=%0b tick#%0d want 3 1 multiple of 3",
                   bus.remain, bus.busy, nt);
        else passed++;
      end
      checks++;
      if ({bus.busy, bus.done, bus.remain} !== {m_busy, m_done, m_remain})
        $display("FAIL periodic_cycle got busy=%0b done=%0b remain=%0d want %0b %0b %0d",
                 bus.busy, bus.done, bus.remain, m_busy, m_done, m_remain);
      else passed++;
    end
    checks++;
    if (ndone !== 3 || bus.remain !== 20'd2 || bus.busy !== 1'b1)
      $display("FAIL periodic_total got done=%0d remain=%0d busy=%0b want 3 2 1", ndone, bus.remain, bus.busy);
    else passed++;
    $display("test_periodic: %0d done pulses over %0d ticks", ndone, nt);
  endtask

  task automatic test_pause_stop();
    int nt, cyc, ndone;
    logic [UP_W-1:0] u0;
    period = 8;
    do_reset();
    bus.start = 1; bus.load_val = 8;
    run_cycle();
    idle_inputs();
    nt = 0; cyc = 0; ndone = 0;
    while (nt < 2 && cyc < 200) begin
      if (bus.tick_us) nt++;
      run_cycle();
      cyc++;
    end
    checks++;
    if (bus.remain !== 20'd6) $display("FAIL pause_pre got remain=%0d want 6", bus.remain);
    else passed++;
    bus.pause = 1;
    u0 = bus.uptime_us;
    for (int i = 0; i < 5 * period; i++) begin
      run_cycle();
      if (bus.done) ndone++;
    end
    checks++;
    if (bus.remain !== 20'd6 || bus.busy !== 1'b1)
      $display("FAIL pause_hold got remain=%0d busy=%0b want 6 1", bus.remain, bus.busy);
    else passed++;
    checks++;
    if (bus.uptime_us !== u0 + 5) $display("FAIL pause_uptime got %0d want %0d", bus.uptime_us, u0 + 5);
    else passed++;
    bus.pause = 0;
    cyc = 0;
    while (bus.remain !== 20'd4 && cyc < 200) begin
      run_cycle();
      if (bus.done) ndone++;
      cyc++;
    end
    checks++;
    if (cyc >= 200) $display("FAIL pause_resume_timeout got remain=%0d want 4", bus.remain);
    else passed++;
    bus.stop = 1;
    run_cycle();
    idle_inputs();
    if (bus.done) ndone++;
    checks++;
    if (bus.busy !== 1'b0 || bus.remain !== 20'd0 || ndone !== 0)
      $display("FAIL stop_abort got busy=%0b remain=%0d dones=%0d want 0 0 0", bus.busy, bus.remain, ndone);
    else passed++;
    $display("test_pause_stop complete");
  endtask

  task automatic test_zero_restart();
    int cyc;
    period = 8;
    do_reset();
    bus.start = 1; bus.load_val = 0; bus.periodic = 1;
    run_cycle();
    idle_inputs();
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL zero_load got done=%0b busy=%0b want 1 0", bus.done, bus.busy);
    else passed++;
    run_cycle();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL zero_single got done=%0b busy=%0b want 0 0", bus.done, bus.busy);
    else passed++;
    bus.start = 1; bus.load_val = 5;
    run_cycle();
    idle_inputs();
    cyc = 0;
    while (bus.remain !== 20'd2 && cyc < 200) begin
      run_cycle();
      cyc++;
    end
    bus.start = 1; bus.load_val = 7;
    run_cycle();
    idle_inputs();
    checks++;
    if (bus.remain !== 20'd7 || bus.done !== 1'b0 || cyc >= 200)
      $display("FAIL restart got remain=%0d done=%0b want 7 0", bus.remain, bus.done);
    else passed++;
    bus.start = 1; bus.stop = 1; bus.load_val = 4;
    run_cycle();
    idle_inputs();
    checks++;
    if (bus.busy !== 1'b0 || bus.remain !== 20'd0 || bus.done !== 1'b0)
      $display("FAIL start_stop got busy=%0b remain=%0d done=%0b want 0 0 0", bus.busy, bus.remain, bus.done);
    else passed++;
    $display("test_zero_restart complete");
  endtask

  task automatic test_reset_mid();
    period = 8;
    do_reset();
    bus.start = 1; bus.load_val = 9;
    run_cycle();
    idle_inputs();
    for (int i = 0; i < 30; i++) run_cycle();
    #2;
    rst = 1;
    #1;
    checks++;
    if ({bus.tick_us, bus.busy, bus.done, bus.remain, bus.uptime_us} !== '0)
      $display("FAIL reset_mid got busy=%0b done=%0b remain=%0d up=%0d want all 0",
               bus.busy, bus.done, bus.remain, bus.uptime_us);
    else passed++;
    do_reset();
    $display("test_reset_mid complete");
  endtask

  task automatic test_wrap();
    int cyc;
    period = 8;
    do_reset();
    cyc = 0;
    while (bus.uptime_us !== 32'd15 && cyc < 500) begin
      run_cycle();
      cyc++;
    end
    checks++;
    if (bus4.uptime_us !== 4'd15 || cyc >= 500)
      $display("FAIL wrap_15 got %0d want 15", bus4.uptime_us);
    else passed++;
    while (bus.uptime_us !== 32'd16 && cyc < 500) begin
      run_cycle();
      cyc++;
    end
    checks++;
    if (bus4.uptime_us !== 4'd0 || cyc >= 500)
      $display("FAIL wrap_0 got %0d want 0", bus4.uptime_us);
    else passed++;
    $display("test_wrap complete");
  endtask

  task automatic test_random();
    period = 6;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bus.start    = ($urandom_range(0, 39) == 0);
      bus.stop     = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 24) == 0) bus.pause = ~bus.pause;
      bus.periodic = $urandom_range(0, 1);
      bus.load_val = CNT_W'($urandom_range(0, 6));
      run_cycle();
      checks++;
      if ({bus.tick_us, bus.busy, bus.done, bus.remain, bus.uptime_us} !==
          {m_tick, m_busy, m_done, m_remain, m_uptime})
        $display("FAIL random_cycle%0d got t=%0b b=%0b d=%0b r=%0d u=%0d want t=%0b b=%0b d=%0b r=%0d u=%0d",
                 i, bus.tick_us, bus.busy, bus.done, bus.remain, bus.uptime_us,
                 m_tick, m_busy, m_done, m_remain, m_uptime);
      else passed++;
    end
    idle_inputs();
    $display("test_random complete");
  endtask

  initial begin
    rst = 1;
    bus.clk_1mhz = 0;
    idle_inputs();
    model_reset();
    test_reset();
    test_tick_rate();
    test_oneshot();
    test_periodic();
    test_pause_stop();
    test_zero_restart();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
